// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg
// Shared constants for the binary-to-seven-segment display slice:
//   - active-low segment codes {g,f,e,d,c,b,a} for digits 0..9, blank, dash
//   - FSM state enumeration for the converter
//   - elaboration-time helper computing the largest displayable value
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // 10^n - 1, the largest value that fits in n decimal digits.
  function automatic logic [31:0] max_display_value(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/seven_seg_digit_enc.sv
// seven_seg_digit_enc
// Combinational encoder for one seven-segment digit (active-low segments).
// Ports:
//   bcd   - 4-bit BCD digit value
//   blank - force all segments off
//   dash  - show a dash (takes priority over blank and the digit value)
//   seg   - segments {g,f,e,d,c,b,a}, active-low
module seven_seg_digit_enc
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        // Non-BCD nibbles only arise when the value overflowed, and that
        // case is already shown as a dash.
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_bin_display.sv
// seven_seg_bin_display
// Converts an unsigned binary value to NUM_DIGITS decimal seven-segment
// digits using the shift-and-add-3 (double dabble) algorithm, one bit per
// clock, then registers the segment pattern.
// Optional build macro: SEVEN_SEG_LZ_BLANK_EN -- blank leading zero digits
// (digit 0 is never blanked). Without it all leading zeros are shown.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset (priority over start)
//   start    - request conversion of bin_in, honoured only in IDLE
//   bin_in   - unsigned value, captured on the accepting edge
//   busy     - high whenever the converter is not idle
//   done     - one-cycle pulse when hex_out/overflow have been updated
//   overflow - last accepted value exceeded 10^NUM_DIGITS-1
//   hex_out  - active-low segments, digit 0 in bits [6:0]
module seven_seg_bin_display
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int          BCD_W   = 4 * NUM_DIGITS;
  localparam int          HEX_W   = 7 * NUM_DIGITS;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam logic [31:0] MAX_VAL = max_display_value(NUM_DIGITS);

  state_t             state_reg, state_next;
  logic [BIN_W-1:0]   bin_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               ovf_pending_reg;
  logic               ovf_reg;
  logic               done_reg;
  logic [HEX_W-1:0]   hex_reg;

  logic               accept;
  logic               shift_en;
  logic               load_en;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W+BIN_W-1:0] shifted;
  logic [NUM_DIGITS-1:0]  blank;
  logic [HEX_W-1:0]   seg_all;
  logic [HEX_W-1:0]   hex_rst;

  // Add-3 correction on every nibble that would exceed 9 after doubling.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {bcd_adj, bin_reg} << 1;

`ifdef SEVEN_SEG_LZ_BLANK_EN
  // A digit is blanked when it and every digit above it are zero.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (bcd_reg[BCD_W-1:gi*4] == '0);
      end
    end
  endgenerate

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_rst
      assign hex_rst[gi*7 +: 7] = (gi == 0) ? SEG_0 : SEG_BLANK;
    end
  endgenerate
`else
  assign blank = '0;

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_rst
      assign hex_rst[gi*7 +: 7] = SEG_0;
    end
  endgenerate
`endif

  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
      seven_seg_digit_enc u_enc (
        .bcd   (bcd_reg[gi*4 +: 4]),
        .blank (blank[gi]),
        .dash  (ovf_pending_reg),
        .seg   (seg_all[gi*7 +: 7])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    shift_en   = 1'b0;
    load_en    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        // cnt_reg == 1 means this edge performs the final shift.
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load_en    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      bin_reg         <= '0;
      bcd_reg         <= '0;
      cnt_reg         <= '0;
      ovf_pending_reg <= 1'b0;
      ovf_reg         <= 1'b0;
      done_reg        <= 1'b0;
      hex_reg         <= hex_rst;
    end else begin
      state_reg <= state_next;
      done_reg  <= load_en;
      if (accept) begin
        bin_reg         <= bin_in;
        bcd_reg         <= '0;
        cnt_reg         <= CNT_W'(BIN_W);
        ovf_pending_reg <= (32'(bin_in) > MAX_VAL);
      end
      if (shift_en) begin
        bcd_reg <= shifted[BCD_W+BIN_W-1:BIN_W];
        bin_reg <= shifted[BIN_W-1:0];
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
      if (load_en) begin
        hex_reg <= seg_all;
        ovf_reg <= ovf_pending_reg;
      end
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign done     = done_reg;
  assign overflow = ovf_reg;
  assign hex_out  = hex_reg;

endmodule

// File: tb/tb_seven_seg_bin_display.sv
// Self-checking bench for seven_seg_bin_display (NUM_DIGITS=4, BIN_W=14).
// Expected displays come from a decimal reference model (divide/modulo per
// digit, table lookup for the segment codes).
module tb_seven_seg_bin_display;

  localparam int ND = 4;
  localparam int BW = 14;
  localparam int LAT = BW + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [BW-1:0]   bin_in;
  logic            busy;
  logic            done;
  logic            overflow;
  logic [7*ND-1:0] hex_out;

  int n_assert = 0;
  int n_fail   = 0;

  seven_seg_bin_display #(.NUM_DIGITS(ND), .BIN_W(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .hex_out  (hex_out)
  );

  always #5 clk = ~clk;

  logic [6:0] code_tbl [10];
  initial begin
    code_tbl[0] = 7'b1000000; code_tbl[1] = 7'b1111001;
    code_tbl[2] = 7'b0100100; code_tbl[3] = 7'b0110000;
    code_tbl[4] = 7'b0011001; code_tbl[5] = 7'b0010010;
    code_tbl[6] = 7'b0000010; code_tbl[7] = 7'b1111000;
    code_tbl[8] = 7'b0000000; code_tbl[9] = 7'b0010000;
  end

`ifdef SEVEN_SEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  function automatic logic [7*ND-1:0] model_hex(input int v);
    logic [7*ND-1:0] h;
    int p;
    h = '0;
    p = 1;
    for (int d = 0; d < ND; d++) begin
      if (v > 9999)               h[d*7 +: 7] = 7'b0111111;
      else if (LZ && d > 0 && v < p) h[d*7 +: 7] = 7'b1111111;
      else                        h[d*7 +: 7] = code_tbl[(v / p) % 10];
      p = p * 10;
    end
    return h;
  endfunction

  function automatic logic [7*ND-1:0] reset_hex();
    logic [7*ND-1:0] h;
    for (int d = 0; d < ND; d++) h[d*7 +: 7] = (d == 0 || !LZ) ? 7'b1000000 : 7'b1111111;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for one edge; returns #1 after the accepting edge with
  // bin_in scrambled to show it is ignored while busy.
  task automatic start_conv(input int v);
    start  = 1'b1;
    bin_in = BW'(v);
    tick();
    start  = 1'b0;
    bin_in = BW'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cyc++;
      if (done) break;
    end
  endtask

  task automatic convert_and_check(input string tag, input int v);
    int cyc;
    start_conv(v);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'(LAT));
    chk({tag, "_hex"}, 32'(hex_out), 32'(model_hex(v)));
    chk({tag, "_ovf"}, 32'(overflow), 32'(v > 9999));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    $display("conv %s value=%0d hex=%07h ovf=%0b cycles=%0d", tag, v, hex_out, overflow, cyc);
  endtask

  initial begin
    int cyc;
    int dones;
    int v;
    rst = 1'b1; start = 1'b0; bin_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_hex", 32'(hex_out), 32'(reset_hex()));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    convert_and_check("v1234", 1234);
    tick();
    chk("done_pulse_len", 32'(done), 32'd0);
    chk("hold_hex", 32'(hex_out), 32'(model_hex(1234)));
    convert_and_check("v9999", 9999);
    convert_and_check("v10000", 10000);
    convert_and_check("v5", 5);
    convert_and_check("v0", 0);
    convert_and_check("v42", 42);
    convert_and_check("v16383", 16383);

    // Start while busy is ignored; start in the done cycle is accepted.
    start_conv(1234);
    tick(); tick();
    start = 1'b1; bin_in = BW'(5678);
    tick();
    start = 1'b0;
    wait_done(cyc);
    chk("busy_ign_latency", 32'(cyc), 32'(LAT - 3));
    chk("busy_ign_hex", 32'(hex_out), 32'(model_hex(1234)));
    $display("conv busy_ignore value=1234 hex=%07h cycles=%0d", hex_out, cyc);
    start = 1'b1; bin_in = BW'(77);
    tick();
    start = 1'b0;
    chk("done_cycle_accept_busy", 32'(busy), 32'd1);
    chk("done_cycle_no_done", 32'(done), 32'd0);
    wait_done(cyc);
    chk("done_cycle_latency", 32'(cyc), 32'(LAT));
    chk("done_cycle_hex", 32'(hex_out), 32'(model_hex(77)));
    $display("conv done_cycle value=77 hex=%07h cycles=%0d", hex_out, cyc);

    for (int i = 0; i < 16; i++) begin
      v = (i % 3 == 0) ? int'($urandom_range(0, 99)) : int'($urandom_range(0, 16383));
      convert_and_check($sformatf("rnd%0d", i), v);
    end

    // Overflow first, then reset (with start) mid-conversion at edge k+7.
    convert_and_check("pre_rst_ovf", 12000);
    start_conv(4321);
    repeat (6) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hex", 32'(hex_out), 32'(reset_hex()));
    chk("midrst_ovf", 32'(overflow), 32'd0);
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("midrst_no_activity", 32'(dones), 32'd0);
    $display("conv mid_reset hex=%07h activity=%0d", hex_out, dones);

    convert_and_check("post_rst", 8086);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
